// File: rtl/mem_bus_ctrl.sv
// Physical bus cycle controller behind the TLB/address-decode stage.
// Sequences SRAM, flash, boot ROM and serial accesses; stalls MEM until ack.
module mem_bus_ctrl #(
    parameter int SRAM_WAIT  = 2,
    parameter int FLASH_WAIT = 6,
    parameter int ROM_WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] paddr_i,
    input  logic        tlb_hit_i,
    input  logic        sram_ce_i,
    input  logic        flash_ce_i,
    input  logic        rom_ce_i,
    input  logic        serial_ce_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        tlb_miss_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o,
    output logic [22:0] flash_addr_o,
    input  logic [15:0] flash_rdata_i,
    output logic        flash_ce_n_o,
    output logic        flash_oe_n_o,
    output logic [9:0]  rom_addr_o,
    input  logic [31:0] rom_rdata_i,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_start_o,
    input  logic        uart_tx_busy_i,
    input  logic [7:0]  uart_rx_data_i,
    output logic        uart_rx_ack_o
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        IDLE,
        SRAM,
        FLASH_LO,
        FLASH_HI,
        ROM,
        UART_WR,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] cnt, cnt_nx;
    logic [23:2]   paddr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic [31:0]   rdata_q, rdata_nx;
    logic          miss_q, miss_nx;
    logic          rx_q, rx_nx;
    logic          tx_start;
    logic          accept;
    logic          sram_act;
    logic          flash_act;

    assign accept = (state == IDLE) && req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            miss_q  <= 1'b0;
            rx_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rdata_q <= rdata_nx;
            miss_q  <= miss_nx;
            rx_q    <= rx_nx;
        end
    end

    // Request attributes stay frozen for the whole bus cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            paddr_q <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
        end else if (accept) begin
            paddr_q <= paddr_i[23:2];
            wdata_q <= wdata_i;
            sel_q   <= sel_i;
            we_q    <= we_i;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rdata_nx = rdata_q;
        miss_nx  = miss_q;
        rx_nx    = rx_q;
        tx_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    rdata_nx = '0;
                    miss_nx  = 1'b0;
                    rx_nx    = 1'b0;
                    state_nx = DONE;
                    if (!tlb_hit_i) begin
                        miss_nx = 1'b1;
                    end else if (sram_ce_i) begin
                        state_nx = SRAM;
                        cnt_nx   = CW'(SRAM_WAIT - 1);
                    end else if (flash_ce_i) begin
                        if (!we_i) begin
                            state_nx = FLASH_LO;
                            cnt_nx   = CW'(FLASH_WAIT - 1);
                        end
                    end else if (rom_ce_i) begin
                        if (!we_i) begin
                            state_nx = ROM;
                            cnt_nx   = CW'(ROM_WAIT - 1);
                        end
                    end else if (serial_ce_i) begin
                        if (we_i) begin
                            state_nx = UART_WR;
                        end else begin
                            rdata_nx = {24'b0, uart_rx_data_i};
                            rx_nx    = 1'b1;
                        end
                    end
                end
            end
            SRAM: begin
                if (cnt == '0) begin
                    if (!we_q) begin
                        rdata_nx = sram_rdata_i;
                    end
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            FLASH_LO: begin
                if (cnt == '0) begin
                    rdata_nx[15:0] = flash_rdata_i;
                    cnt_nx         = CW'(FLASH_WAIT - 1);
                    state_nx       = FLASH_HI;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            FLASH_HI: begin
                if (cnt == '0) begin
                    rdata_nx[31:16] = flash_rdata_i;
                    state_nx        = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ROM: begin
                if (cnt == '0) begin
                    rdata_nx = rom_rdata_i;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            UART_WR: begin
                if (!uart_tx_busy_i) begin
                    tx_start = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign sram_act  = (state == SRAM);
    assign flash_act = (state == FLASH_LO) || (state == FLASH_HI);

    assign ack_o      = (state == DONE);
    assign tlb_miss_o = ack_o && miss_q;
    assign stall_o    = req_i && !ack_o;
    assign rdata_o    = rdata_q;

    assign sram_addr_o  = paddr_q[21:2];
    assign sram_wdata_o = wdata_q;
    assign sram_ce_n_o  = !sram_act;
    assign sram_oe_n_o  = !(sram_act && !we_q);
    assign sram_we_n_o  = !(sram_act && we_q);
    // Reads enable every lane; only writes honour the byte selects.
    assign sram_be_n_o  = sram_act ? (we_q ? ~sel_q : 4'h0) : 4'hF;

    assign flash_addr_o = {paddr_q[23:2], state == FLASH_HI};
    assign flash_ce_n_o = !flash_act;
    assign flash_oe_n_o = !flash_act;

    assign rom_addr_o = paddr_q[11:2];

    assign uart_tx_data_o  = wdata_q[7:0];
    assign uart_tx_start_o = tx_start;
    assign uart_rx_ack_o   = ack_o && rx_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with simple SRAM/flash/ROM device
// models and a scoreboard of expected read data.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, tlb_hit_i;
    logic [3:0]  sel_i;
    logic [31:0] wdata_i, paddr_i;
    logic        sram_ce_i, flash_ce_i, rom_ce_i, serial_ce_i;
    logic [31:0] rdata_o;
    logic        ack_o, stall_o, tlb_miss_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_wdata_o, sram_rdata_i;
    logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [3:0]  sram_be_n_o;
    logic [22:0] flash_addr_o;
    logic [15:0] flash_rdata_i;
    logic        flash_ce_n_o, flash_oe_n_o;
    logic [9:0]  rom_addr_o;
    logic [31:0] rom_rdata_i;
    logic [7:0]  uart_tx_data_o;
    logic        uart_tx_start_o, uart_tx_busy_i;
    logic [7:0]  uart_rx_data_i;
    logic        uart_rx_ack_o;

    mem_bus_ctrl #(.SRAM_WAIT(2), .FLASH_WAIT(6), .ROM_WAIT(1)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .sel_i(sel_i),
        .wdata_i(wdata_i), .paddr_i(paddr_i), .tlb_hit_i(tlb_hit_i),
        .sram_ce_i(sram_ce_i), .flash_ce_i(flash_ce_i),
        .rom_ce_i(rom_ce_i), .serial_ce_i(serial_ce_i),
        .rdata_o(rdata_o), .ack_o(ack_o), .stall_o(stall_o),
        .tlb_miss_o(tlb_miss_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o),
        .flash_addr_o(flash_addr_o), .flash_rdata_i(flash_rdata_i),
        .flash_ce_n_o(flash_ce_n_o), .flash_oe_n_o(flash_oe_n_o),
        .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i),
        .uart_tx_data_o(uart_tx_data_o), .uart_tx_start_o(uart_tx_start_o),
        .uart_tx_busy_i(uart_tx_busy_i), .uart_rx_data_i(uart_rx_data_i),
        .uart_rx_ack_o(uart_rx_ack_o)
    );

    always #5 clk = ~clk;

    // Device models
    logic [31:0] sram_mem [0:255];
    logic [15:0] flash_lo, flash_hi;

    always @(posedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n_o[b])
                    sram_mem[sram_addr_o[7:0]][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end
        end
    end

    assign sram_rdata_i  = sram_mem[sram_addr_o[7:0]];
    assign flash_rdata_i = flash_addr_o[0] ? flash_hi : flash_lo;
    assign rom_rdata_i   = {rom_addr_o, 12'hC0D, ~rom_addr_o};

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {a, 12'hC0D, ~a};
    endfunction

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    int          ack_cyc, n_we, n_oe, n_fce, n_low, n_stall, n_tx, tx_cyc;
    int          n_rxack, busy_len;
    logic        got, ack_miss;
    logic [31:0] ack_rdata;
    logic [19:0] sram_addr_seen;
    logic [3:0]  be_seen;
    logic [22:0] faddr_first;
    logic [7:0]  tx_data_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 0; we_i = 0; sel_i = 0; wdata_i = 0; paddr_i = 0;
        tlb_hit_i = 0; sram_ce_i = 0; flash_ce_i = 0; rom_ce_i = 0;
        serial_ce_i = 0; uart_tx_busy_i = 0;
    endtask

    // Drives one request from IDLE and observes the bus until ack.
    task automatic run_req(input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, input logic [31:0] pa,
                           input logic hit, input logic [3:0] ce);
        we_i = we; sel_i = sel; wdata_i = wd; paddr_i = pa; tlb_hit_i = hit;
        {serial_ce_i, rom_ce_i, flash_ce_i, sram_ce_i} = ce;
        req_i = 1;
        got = 0; ack_cyc = -1; n_we = 0; n_oe = 0; n_fce = 0; n_low = 0;
        n_stall = 0; n_tx = 0; tx_cyc = -1; n_rxack = 0; ack_miss = 0;
        ack_rdata = '0; sram_addr_seen = '1; be_seen = 'x; faddr_first = '1;
        tx_data_seen = '0;
        for (int k = 0; k < 200 && !got; k++) begin
            uart_tx_busy_i = (k < busy_len);
            #1;
            if (stall_o) n_stall++;
            if (!sram_we_n_o) begin
                n_we++; sram_addr_seen = sram_addr_o; be_seen = sram_be_n_o;
            end
            if (!sram_oe_n_o) begin
                n_oe++; sram_addr_seen = sram_addr_o; be_seen = sram_be_n_o;
            end
            if (!flash_ce_n_o) begin
                if (n_fce == 0) faddr_first = flash_addr_o;
                n_fce++;
            end
            if (!sram_ce_n_o || !sram_oe_n_o || !sram_we_n_o ||
                !flash_ce_n_o || !flash_oe_n_o) n_low++;
            if (uart_tx_start_o) begin
                n_tx++; tx_cyc = k; tx_data_seen = uart_tx_data_o;
            end
            if (uart_rx_ack_o) n_rxack++;
            if (ack_o) begin
                got = 1; ack_cyc = k; ack_rdata = rdata_o; ack_miss = tlb_miss_o;
            end else begin
                tick();
            end
        end
        idle_inputs();
        busy_len = 0;
        tick();
    endtask

    task automatic check_pop(input string nm);
        tests++;
        if (!got) begin
            fails++; $display("FAIL %s timeout: no ack within budget", nm);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            exp_v = exp_q.pop_front();
            if (ack_rdata !== exp_v) begin
                fails++;
                $display("FAIL %s rdata got %08h want %08h", nm, ack_rdata, exp_v);
            end
        end
    endtask

    task automatic check_int(input string nm, input int got_v, input int want);
        tests++;
        if (got_v !== want) begin
            fails++; $display("FAIL %s got %0d want %0d", nm, got_v, want);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        #1;
        check_int("rst_ack", int'(ack_o), 0);
        check_int("rst_strobes", int'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
                  flash_ce_n_o, flash_oe_n_o}), 31);
        check_int("rst_pulses", int'({tlb_miss_o, uart_tx_start_o, uart_rx_ack_o}), 0);
        tests++;
        if (rdata_o !== 32'h0 || sram_addr_o !== 20'h0 || rom_addr_o !== 10'h0) begin
            fails++;
            $display("FAIL rst_regs got rdata=%08h sram_addr=%05h rom=%03h want 0",
                     rdata_o, sram_addr_o, rom_addr_o);
        end
        check_int("rst_stall", int'(stall_o), 0);
        tick();
    endtask

    task automatic test_sram();
        run_req(1, 4'hF, 32'hDEADBEEF, 32'h0000_0100, 1, 4'b0001);
        check_int("sram_wr_lat", ack_cyc, 3);
        check_int("sram_wr_we_cycles", n_we, 2);
        check_int("sram_wr_oe_cycles", n_oe, 0);
        check_int("sram_wr_addr", int'(sram_addr_seen), 32'h40);
        check_int("sram_wr_be", int'(be_seen), 0);
        exp_q.push_back(32'hDEADBEEF);
        run_req(0, 4'hF, 32'h0, 32'h0000_0100, 1, 4'b0001);
        check_pop("sram_rd");
        check_int("sram_rd_lat", ack_cyc, 3);
        check_int("sram_rd_oe_cycles", n_oe, 2);
        check_int("sram_rd_stall", n_stall, 3);
        run_req(1, 4'hF, 32'hAAAAAAAA, 32'h0000_0104, 1, 4'b0001);
        run_req(1, 4'b0011, 32'h11223344, 32'h0000_0104, 1, 4'b0001);
        check_int("sram_part_be", int'(be_seen), 4'b1100);
        exp_q.push_back(32'hAAAA3344);
        run_req(0, 4'b0011, 32'h0, 32'h0000_0104, 1, 4'b0001);
        check_pop("sram_part_rd");
        check_int("sram_rd_be", int'(be_seen), 0);
    endtask

    task automatic test_flash();
        flash_lo = 16'h1234; flash_hi = 16'hABCD;
        exp_q.push_back(32'hABCD1234);
        run_req(0, 4'hF, 32'h0, 32'h0000_0010, 1, 4'b0010);
        check_pop("flash_rd");
        check_int("flash_lat", ack_cyc, 13);
        check_int("flash_stall", n_stall, 13);
        check_int("flash_ce_cycles", n_fce, 12);
        check_int("flash_addr_lo", int'(faddr_first), 8);
        run_req(1, 4'hF, 32'h55, 32'h0000_0010, 1, 4'b0010);
        check_int("flash_wr_lat", ack_cyc, 1);
        check_int("flash_wr_ce", n_fce, 0);
    endtask

    task automatic test_tlb_miss();
        exp_q.push_back(32'h0);
        run_req(0, 4'hF, 32'h0, 32'h0000_0100, 0, 4'b0001);
        check_pop("miss_rd");
        check_int("miss_lat", ack_cyc, 1);
        check_int("miss_flag", int'(ack_miss), 1);
        check_int("miss_strobes", n_low, 0);
        exp_q.push_back(32'h0);
        run_req(0, 4'hF, 32'h0, 32'h0000_0200, 1, 4'b0000);
        check_pop("noce_rd");
        check_int("noce_miss", int'(ack_miss), 0);
    endtask

    task automatic test_serial();
        busy_len = 5;
        run_req(1, 4'h1, 32'h0000_0041, 32'h1000_0000, 1, 4'b1000);
        check_int("tx_pulses", n_tx, 1);
        check_int("tx_cycle", tx_cyc, 5);
        check_int("tx_data", int'(tx_data_seen), 32'h41);
        check_int("tx_ack_lat", ack_cyc, 6);
        uart_rx_data_i = 8'h5A;
        exp_q.push_back(32'h0000_005A);
        run_req(0, 4'hF, 32'h0, 32'h1000_0000, 1, 4'b1000);
        check_pop("rx_rd");
        check_int("rx_ack", n_rxack, 1);
        check_int("rx_lat", ack_cyc, 1);
    endtask

    task automatic test_reset_abort();
        int n_ack, n_fl;
        paddr_i = 32'h0000_0020; we_i = 0; sel_i = 4'hF; tlb_hit_i = 1;
        flash_ce_i = 1; req_i = 1;
        tick();
        tick();
        check_int("abort_flash_active", int'(flash_ce_n_o), 0);
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        #1;
        check_int("abort_flash_ce_n", int'(flash_ce_n_o), 1);
        check_int("abort_ack", int'(ack_o), 0);
        n_ack = 0; n_fl = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ack_o) n_ack++;
            if (!flash_ce_n_o) n_fl++;
        end
        check_int("abort_no_ack", n_ack, 0);
        check_int("abort_no_flash", n_fl, 0);
    endtask

    task automatic test_back_to_back();
        int acks[2];
        int n_ack;
        n_ack = 0; acks[0] = -1; acks[1] = -1;
        exp_q.push_back(rom_word(10'h081));
        exp_q.push_back(rom_word(10'h3FF));
        paddr_i = 32'h0000_0204; we_i = 0; sel_i = 4'hF; tlb_hit_i = 1;
        rom_ce_i = 1; req_i = 1;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (ack_o && n_ack < 2) begin
                acks[n_ack] = k;
                exp_v = exp_q.pop_front();
                tests++;
                if (rdata_o !== exp_v) begin
                    fails++;
                    $display("FAIL b2b_rdata%0d got %08h want %08h", n_ack, rdata_o, exp_v);
                end
                n_ack++;
                if (n_ack == 1) paddr_i = 32'h0000_0FFC;
                else idle_inputs();
            end
            tick();
        end
        check_int("b2b_count", n_ack, 2);
        check_int("b2b_ack0", acks[0], 2);
        check_int("b2b_ack1", acks[1], 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        busy_len = 0;
        uart_rx_data_i = 8'h00;
        flash_lo = 16'h0; flash_hi = 16'h0;
        idle_inputs();
        test_reset();
        test_sram();
        test_flash();
        test_tlb_miss();
        test_serial();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
